// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch next-PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'b00,
    PC_BTB   = 2'b01,
    PC_RAS   = 2'b10,
    PC_REDIR = 2'b11
  } pc_src_e;

  // Number of always-zero low address bits for a given instruction size.
  function automatic int unsigned align_bits(input int unsigned inst_bytes);
    return $clog2(inst_bytes);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack: push overwrites the oldest entry when full,
// a combined push+pop replaces the top in place, flush_ops discards both.
module ras_stack
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  input  logic            flush_ops,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  entries [RAS_DEPTH];
  logic [PTR_W-1:0] ptr, ptr_next, wr_idx;
  logic [CNT_W-1:0] count, count_next;
  logic             do_push, do_pop, wr_en;

  assign do_push = push && !flush_ops;
  assign do_pop  = pop && !flush_ops && (count != '0);
  assign top     = entries[ptr];

  // Pointer/count update and write-port selection.
  always_comb begin
    ptr_next   = ptr;
    count_next = count;
    wr_en      = 1'b0;
    wr_idx     = ptr + PTR_W'(1);
    if (do_push && do_pop) begin
      wr_en  = 1'b1;
      wr_idx = ptr;
    end else if (do_push) begin
      wr_en    = 1'b1;
      ptr_next = ptr + PTR_W'(1);
      if (count != DEPTH_CNT) count_next = count + CNT_W'(1);
    end else if (do_pop) begin
      ptr_next   = ptr - PTR_W'(1);
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= ptr_next;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
    end
  end

  // Entry storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en) entries[wr_idx] <= push_addr;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register with redirect > RAS > BTB > sequential next-PC selection.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int unsigned     RAS_DEPTH  = 8,
  parameter int unsigned     INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            btb_hit_i,
  input  logic [XLEN-1:0] btb_target_i,
  input  logic            ras_push_i,
  input  logic [XLEN-1:0] ras_push_addr_i,
  input  logic            ras_pop_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic [1:0]      pc_src_o,
  output logic            pred_taken_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  localparam int unsigned     ALIGN      = align_bits(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN) - XLEN'(1));

  logic [XLEN-1:0] ras_top;
  pc_src_e         src_next;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push_i),
    .push_addr (ras_push_addr_i),
    .pop       (ras_pop_i),
    .flush_ops (ex_redirect_i),
    .top       (ras_top),
    .empty     (ras_empty_o),
    .full      (ras_full_o)
  );

  // An empty-RAS pop falls through to BTB/sequential.
  always_comb begin
    pc_next_o = pc_o + XLEN'(INST_BYTES);
    src_next  = PC_SEQ;
    if (ex_redirect_i) begin
      pc_next_o = ex_target_i & ALIGN_MASK;
      src_next  = PC_REDIR;
    end else if (ras_pop_i && !ras_empty_o) begin
      pc_next_o = ras_top;
      src_next  = PC_RAS;
    end else if (btb_hit_i) begin
      pc_next_o = btb_target_i;
      src_next  = PC_BTB;
    end
  end

  // Redirect overrides stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o         <= RESET_VEC;
      pc_src_o     <= PC_SEQ;
      pred_taken_o <= 1'b0;
    end else if (!stall_i || ex_redirect_i) begin
      pc_o         <= pc_next_o;
      pc_src_o     <= src_next;
      pred_taken_o <= (src_next == PC_BTB) || (src_next == PC_RAS);
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed scoreboard bench for pc_gen_unit.
module tb_pc_gen_unit;

  localparam logic [1:0] SEQ = 2'b00, BTB = 2'b01, RAS = 2'b10, RED = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, btb_hit_i, ras_push_i, ras_pop_i, ex_redirect_i;
  logic [31:0] btb_target_i, ras_push_addr_i, ex_target_i;
  logic [31:0] pc_o, pc_next_o;
  logic [1:0]  pc_src_o;
  logic        pred_taken_o, ras_empty_o, ras_full_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  src;
    logic        pred;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pc_gen_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .btb_hit_i       (btb_hit_i),
    .btb_target_i    (btb_target_i),
    .ras_push_i      (ras_push_i),
    .ras_push_addr_i (ras_push_addr_i),
    .ras_pop_i       (ras_pop_i),
    .ex_redirect_i   (ex_redirect_i),
    .ex_target_i     (ex_target_i),
    .pc_o            (pc_o),
    .pc_next_o       (pc_next_o),
    .pc_src_o        (pc_src_o),
    .pred_taken_o    (pred_taken_o),
    .ras_empty_o     (ras_empty_o),
    .ras_full_o      (ras_full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; btb_hit_i = 0; ras_push_i = 0; ras_pop_i = 0; ex_redirect_i = 0;
    btb_target_i = '0; ras_push_addr_i = '0; ex_target_i = '0;
  endtask

  // Queue the expectation, clock once, then score the registered outputs.
  task automatic cycle(input string tag, input logic [31:0] pc, input logic [1:0] src,
                       input logic pred);
    exp_t e;
    q.push_back('{pc: pc, src: src, pred: pred});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".pc"}, pc_o, e.pc);
    check({tag, ".src"}, {30'b0, pc_src_o}, {30'b0, e.src});
    check({tag, ".pred"}, {31'b0, pred_taken_o}, {31'b0, e.pred});
    idle();
  endtask

  task automatic push(input string tag, input logic [31:0] a, input logic [31:0] pc);
    ras_push_i = 1; ras_push_addr_i = a;
    cycle(tag, pc, SEQ, 0);
  endtask

  task automatic pop(input string tag, input logic [31:0] pc, input logic [1:0] src,
                     input logic pred);
    ras_pop_i = 1;
    cycle(tag, pc, src, pred);
  endtask

  initial begin
    logic [31:0] seq_pc;
    idle();
    rst_n = 0;
    #12;
    check("rst.pc", pc_o, 32'h0);
    check("rst.src", {30'b0, pc_src_o}, {30'b0, SEQ});
    check("rst.pred", {31'b0, pred_taken_o}, 32'h0);
    check("rst.empty", {31'b0, ras_empty_o}, 32'h1);
    check("rst.full", {31'b0, ras_full_o}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    check("seq.next0", pc_next_o, 32'h4);
    cycle("seq1", 32'h4, SEQ, 0);
    cycle("seq2", 32'h8, SEQ, 0);
    cycle("seq3", 32'hC, SEQ, 0);

    // Priority: redirect beats RAS and BTB, and squashes the pop.
    push("prio.push", 32'h200, 32'h10);
    btb_hit_i = 1; btb_target_i = 32'h100;
    ras_pop_i = 1; ex_redirect_i = 1; ex_target_i = 32'h303;
    cycle("prio", 32'h300, RED, 0);
    check("prio.notempty", {31'b0, ras_empty_o}, 32'h0);
    pop("prio.pop", 32'h200, RAS, 1);
    check("prio.empty", {31'b0, ras_empty_o}, 32'h1);

    // Stall holds PC; redirect breaks through.
    ex_redirect_i = 1; ex_target_i = 32'h40;
    cycle("stall.setup", 32'h40, RED, 0);
    for (int i = 0; i < 3; i++) begin
      stall_i = 1; btb_hit_i = 1; btb_target_i = 32'h100;
      cycle("stall.hold", 32'h40, RED, 0);
    end
    stall_i = 1; ex_redirect_i = 1; ex_target_i = 32'h80;
    cycle("stall.redir", 32'h80, RED, 0);
    btb_hit_i = 1; btb_target_i = 32'h100;
    cycle("btb", 32'h100, BTB, 1);
    cycle("btb.seq", 32'h104, SEQ, 0);

    // RAS LIFO order and empty-pop fall-through.
    push("ord.p0", 32'h10, 32'h108);
    push("ord.p1", 32'h20, 32'h10C);
    push("ord.p2", 32'h30, 32'h110);
    pop("ord.q0", 32'h30, RAS, 1);
    pop("ord.q1", 32'h20, RAS, 1);
    pop("ord.q2", 32'h10, RAS, 1);
    pop("ord.q3", 32'h14, SEQ, 0);
    check("ord.empty", {31'b0, ras_empty_o}, 32'h1);

    // Overflow: 10 pushes into 8 entries keep the newest 8.
    seq_pc = 32'h14;
    for (int i = 0; i < 10; i++) begin
      seq_pc += 32'h4;
      push("ovf.push", 32'h1000 + 32'(4 * i), seq_pc);
    end
    check("ovf.full", {31'b0, ras_full_o}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      pop("ovf.pop", 32'h1024 - 32'(4 * i), RAS, 1);
      if (i == 0) check("ovf.notfull", {31'b0, ras_full_o}, 32'h0);
    end
    check("ovf.empty", {31'b0, ras_empty_o}, 32'h1);

    // Simultaneous push/pop replaces top in place.
    push("sim.p0", 32'h40, 32'h100C);
    push("sim.p1", 32'h50, 32'h1010);
    ras_push_i = 1; ras_push_addr_i = 32'h90;
    pop("sim.both", 32'h50, RAS, 1);
    pop("sim.q0", 32'h90, RAS, 1);
    pop("sim.q1", 32'h40, RAS, 1);
    check("sim.empty", {31'b0, ras_empty_o}, 32'h1);
    ras_push_i = 1; ras_push_addr_i = 32'hA0;
    pop("sim.emptyboth", 32'h44, SEQ, 0);
    pop("sim.q2", 32'hA0, RAS, 1);

    // Push alongside a redirect is discarded.
    ras_push_i = 1; ras_push_addr_i = 32'hB0;
    ex_redirect_i = 1; ex_target_i = 32'h200;
    cycle("flush", 32'h200, RED, 0);
    check("flush.empty", {31'b0, ras_empty_o}, 32'h1);

    // Sequential wrap at the top of the address space.
    ex_redirect_i = 1; ex_target_i = 32'hFFFF_FFFE;
    cycle("wrap.redir", 32'hFFFF_FFFC, RED, 0);
    cycle("wrap", 32'h0, SEQ, 0);

    // Asynchronous reset mid-operation.
    push("mid.push", 32'h77, 32'h4);
    btb_hit_i = 1; btb_target_i = 32'h500;
    cycle("mid.btb", 32'h500, BTB, 1);
    #2;
    rst_n = 0;
    #1;
    check("mid.pc", pc_o, 32'h0);
    check("mid.pred", {31'b0, pred_taken_o}, 32'h0);
    check("mid.empty", {31'b0, ras_empty_o}, 32'h1);
    @(negedge clk);
    rst_n = 1;
    check("mid.next", pc_next_o, 32'h4);
    pop("mid.pop", 32'h4, SEQ, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
